// File: rtl/min_pkg.sv
// ----------------------------------------------------------------------------
// min_pkg
// Shared definitions for the MIN framing transmitter and receiver:
// framing byte values, CRC-32/ISO-HDLC constants and the decoder state type.
// No ports (package).
// ----------------------------------------------------------------------------
package min_pkg;

   localparam logic [7:0]  MIN_SOF_BYTE   = 8'hAA;
   localparam logic [7:0]  MIN_STUFF_BYTE = 8'h55;
   localparam logic [7:0]  MIN_EOF_BYTE   = 8'h55;

   localparam logic [31:0] MIN_CRC_POLY   = 32'hEDB88320;
   localparam logic [31:0] MIN_CRC_INIT   = 32'hFFFFFFFF;
   localparam logic [31:0] MIN_CRC_XOROUT = 32'hFFFFFFFF;

   typedef enum logic [2:0] {
      ST_SOF,
      ST_ID,
      ST_LEN,
      ST_PAYLOAD,
      ST_CRC,
      ST_EOF
   } min_state_e;

   // Value that goes on the wire for a running CRC register.
   function automatic logic [31:0] min_crc_final(input logic [31:0] i_crc);
      return i_crc ^ MIN_CRC_XOROUT;
   endfunction

endpackage

// File: rtl/min_receive_fsm_if.sv
// ----------------------------------------------------------------------------
// min_receive_fsm_if
// Byte-stream input and decoded-frame output bundle of the MIN receiver.
//   i_en/i_data            : received byte strobe and value (driven by master)
//   o_id/o_len/o_data      : last good frame contents (driven by slave)
//   o_valid/o_crc_err/
//   o_frame_err            : one-cycle result pulses
//   o_busy                 : decoder is inside a frame
// ----------------------------------------------------------------------------
interface min_receive_fsm_if #(
   parameter int N_DATA_BYTE = 4
);
   logic                     i_en;
   logic [7:0]               i_data;
   logic [7:0]               o_id;
   logic [7:0]               o_len;
   logic [8*N_DATA_BYTE-1:0] o_data;
   logic                     o_valid;
   logic                     o_crc_err;
   logic                     o_frame_err;
   logic                     o_busy;

   modport master (
      output i_en, i_data,
      input  o_id, o_len, o_data, o_valid, o_crc_err, o_frame_err, o_busy
   );

   modport slave (
      input  i_en, i_data,
      output o_id, o_len, o_data, o_valid, o_crc_err, o_frame_err, o_busy
   );
endinterface

// File: rtl/crc32_byte.sv
// ----------------------------------------------------------------------------
// crc32_byte
// Combinational byte-wise update of a reflected CRC-32 register.
//   i_crc  : running CRC register (not yet final-XORed)
//   i_byte : byte to absorb, LSB first
//   o_crc  : updated register
// ----------------------------------------------------------------------------
module crc32_byte
   import min_pkg::*;
(
   input  logic [31:0] i_crc,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_crc
);

   logic [31:0] w_c;

   always_comb begin
      w_c = i_crc ^ {24'h000000, i_byte};
      for (int k = 0; k < 8; k++) begin
         w_c = w_c[0] ? ((w_c >> 1) ^ MIN_CRC_POLY) : (w_c >> 1);
      end
      o_crc = w_c;
   end

endmodule

// File: rtl/min_receive_fsm.sv
// ----------------------------------------------------------------------------
// min_receive_fsm
// Receive-side MIN framing decoder: finds AA AA AA headers, removes stuff
// bytes, checks CRC-32 over ID/LEN/payload and delivers one left-justified
// payload word per good frame.
//   i_clk, i_rst : clock and synchronous active-high reset
//   bus (slave)  : i_en/i_data byte stream in; o_id/o_len/o_data, result
//                  pulses o_valid/o_crc_err/o_frame_err, and o_busy out
// ----------------------------------------------------------------------------
module min_receive_fsm
   import min_pkg::*;
#(
   parameter int N_DATA_BYTE = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   min_receive_fsm_if.slave   bus
);

   localparam int         DW      = 8 * N_DATA_BYTE;
   localparam logic [7:0] LEN_MAX = 8'(N_DATA_BYTE);

   min_state_e      r_state, w_state_nxt;
   logic [1:0]      r_aa_cnt, w_aa_cnt_nxt;
   logic [7:0]      r_idx;
   logic [31:0]     r_crc;
   logic [31:0]     r_rx_crc;
   logic [7:0]      r_id_lat, r_len_lat;
   logic [DW-1:0]   r_pay;
   logic [7:0]      r_id, r_len;
   logic [DW-1:0]   r_data;
   logic            r_valid, r_crc_err, r_frame_err;

   logic [31:0]     w_crc_nxt;
   logic [7:0]      w_pad_bytes;
   logic [DW-1:0]   w_aligned;
   logic            w_is_aa, w_in_body;
   logic            w_crc_init, w_crc_upd, w_id_ld, w_len_ld, w_pay_ld, w_rx_ld;
   logic            w_idx_clr, w_idx_inc, w_good, w_crc_bad, w_frm_bad;

   crc32_byte u_crc (
      .i_crc  (r_crc),
      .i_byte (bus.i_data),
      .o_crc  (w_crc_nxt)
   );

   assign w_is_aa   = (bus.i_data == MIN_SOF_BYTE);
   // EOF is reached by count, so only ID..CRC bytes are candidates for stuffing.
   assign w_in_body = (r_state == ST_ID) || (r_state == ST_LEN) ||
                      (r_state == ST_PAYLOAD) || (r_state == ST_CRC);

   // Payload is shifted in from the bottom; short frames move up to the MSBs.
   assign w_pad_bytes = LEN_MAX - r_len_lat;
   assign w_aligned   = r_pay << {w_pad_bytes, 3'b000};

   always_comb begin
      w_state_nxt  = r_state;
      w_aa_cnt_nxt = r_aa_cnt;
      w_crc_init   = 1'b0;
      w_crc_upd    = 1'b0;
      w_id_ld      = 1'b0;
      w_len_ld     = 1'b0;
      w_pay_ld     = 1'b0;
      w_rx_ld      = 1'b0;
      w_idx_clr    = 1'b0;
      w_idx_inc    = 1'b0;
      w_good       = 1'b0;
      w_crc_bad    = 1'b0;
      w_frm_bad    = 1'b0;

      if (bus.i_en) begin
         // One run counter serves both header detection and unstuffing:
         // a header or a stuff byte both end the run.
         w_aa_cnt_nxt = (w_is_aa && r_aa_cnt != 2'd2) ? r_aa_cnt + 2'd1 : 2'd0;

         if (w_is_aa && r_aa_cnt == 2'd2) begin
            // Header wins in every state; mid-frame it is a silent resync.
            w_state_nxt = ST_ID;
            w_crc_init  = 1'b1;
            w_idx_clr   = 1'b1;
         end else if (w_in_body && bus.i_data == MIN_STUFF_BYTE && r_aa_cnt == 2'd2) begin
            // Stuff byte: dropped, not counted, not in the CRC.
         end else begin
            case (r_state)
               ST_SOF: begin
               end
               ST_ID: begin
                  w_id_ld   = 1'b1;
                  w_crc_upd = 1'b1;
                  if (bus.i_data[7]) begin
                     w_frm_bad   = 1'b1;
                     w_state_nxt = ST_SOF;
                  end else begin
                     w_state_nxt = ST_LEN;
                  end
               end
               ST_LEN: begin
                  w_len_ld  = 1'b1;
                  w_crc_upd = 1'b1;
                  w_idx_clr = 1'b1;
                  if (bus.i_data > LEN_MAX) begin
                     w_frm_bad   = 1'b1;
                     w_state_nxt = ST_SOF;
                  end else if (bus.i_data == 8'd0) begin
                     w_state_nxt = ST_CRC;
                  end else begin
                     w_state_nxt = ST_PAYLOAD;
                  end
               end
               ST_PAYLOAD: begin
                  w_pay_ld  = 1'b1;
                  w_crc_upd = 1'b1;
                  if (r_idx == r_len_lat - 8'd1) begin
                     w_state_nxt = ST_CRC;
                     w_idx_clr   = 1'b1;
                  end else begin
                     w_idx_inc = 1'b1;
                  end
               end
               ST_CRC: begin
                  w_rx_ld = 1'b1;
                  if (r_idx == 8'd3) begin
                     w_state_nxt = ST_EOF;
                     w_idx_clr   = 1'b1;
                  end else begin
                     w_idx_inc = 1'b1;
                  end
               end
               ST_EOF: begin
                  w_state_nxt = ST_SOF;
                  if (bus.i_data != MIN_EOF_BYTE) begin
                     w_frm_bad = 1'b1;
                  end else if (min_crc_final(r_crc) != r_rx_crc) begin
                     w_crc_bad = 1'b1;
                  end else begin
                     w_good = 1'b1;
                  end
               end
               default: w_state_nxt = ST_SOF;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_SOF;
         r_aa_cnt    <= 2'd0;
         r_idx       <= 8'd0;
         r_crc       <= MIN_CRC_INIT;
         r_id        <= 8'd0;
         r_len       <= 8'd0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_crc_err   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_aa_cnt    <= w_aa_cnt_nxt;
         r_valid     <= w_good;
         r_crc_err   <= w_crc_bad;
         r_frame_err <= w_frm_bad;
         if (w_crc_init)     r_crc <= MIN_CRC_INIT;
         else if (w_crc_upd) r_crc <= w_crc_nxt;
         if (w_idx_clr)      r_idx <= 8'd0;
         else if (w_idx_inc) r_idx <= r_idx + 8'd1;
         if (w_good) begin
            r_id   <= r_id_lat;
            r_len  <= r_len_lat;
            r_data <= w_aligned;
         end
      end
   end

   // Frame scratch registers: always rewritten before being used.
   always_ff @(posedge i_clk) begin
      if (w_id_ld)  r_id_lat  <= bus.i_data;
      if (w_len_ld) r_len_lat <= bus.i_data;
      if (w_len_ld)      r_pay <= '0;
      else if (w_pay_ld) r_pay <= (r_pay << 8) | DW'(bus.i_data);
      if (w_rx_ld)  r_rx_crc <= {r_rx_crc[23:0], bus.i_data};
   end

   assign bus.o_id        = r_id;
   assign bus.o_len       = r_len;
   assign bus.o_data      = r_data;
   assign bus.o_valid     = r_valid;
   assign bus.o_crc_err   = r_crc_err;
   assign bus.o_frame_err = r_frame_err;
   assign bus.o_busy      = (r_state != ST_SOF);

endmodule

// File: tb/tb_min_receive_fsm.sv
// ----------------------------------------------------------------------------
// tb_min_receive_fsm
// Directed-vector bench for min_receive_fsm. Frames are assembled from their
// logical contents (ID, LEN, payload); stuffing, CRC and the expected outcome
// of each byte are derived from the framing rules and checked every cycle.
// ----------------------------------------------------------------------------
module tb_min_receive_fsm;

   localparam int NB        = 4;
   localparam int EV_NONE   = 0;
   localparam int EV_VALID  = 1;
   localparam int EV_CRC    = 2;
   localparam int EV_FRM    = 3;
   localparam int BUSY_KEEP = 2;

   typedef logic [7:0] byte_q_t[$];
   typedef struct {
      logic [7:0]  b;
      int          busy;
      int          ev;
      logic [7:0]  id;
      logic [7:0]  len;
      logic [31:0] data;
   } ann_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   min_receive_fsm_if #(.N_DATA_BYTE(NB)) bus ();
   min_receive_fsm #(.N_DATA_BYTE(NB)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   ann_t        txq[$];
   int          body_aa;
   logic [7:0]  e_id, e_len;
   logic [31:0] e_data;
   logic        e_valid, e_crc, e_frm, e_busy;
   bit          chk_en = 1'b0;
   int          errors = 0;
   int          checks = 0;
   int          valid_seen = 0, crc_seen = 0, frm_seen = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] crc_ref(input byte_q_t q);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (q[i]) begin
         c = c ^ {24'h0, q[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   // ---------------- frame builder (transmit-side view) ----------------
   task automatic push(input logic [7:0] b, input int busy, input int ev);
      ann_t a;
      a.b = b; a.busy = busy; a.ev = ev; a.id = 8'h0; a.len = 8'h0; a.data = 32'h0;
      txq.push_back(a);
   endtask

   task automatic add_hdr();
      push(8'hAA, BUSY_KEEP, EV_NONE);
      push(8'hAA, BUSY_KEEP, EV_NONE);
      push(8'hAA, 1, EV_NONE);
      body_aa = 0;
   endtask

   task automatic add_body(input logic [7:0] b, input int busy, input int ev);
      push(b, busy, ev);
      if (b == 8'hAA) begin
         body_aa++;
         if (body_aa == 2) begin
            push(8'h55, 1, EV_NONE);
            body_aa = 0;
         end
      end else begin
         body_aa = 0;
      end
   endtask

   task automatic add_frame(input logic [7:0] id, input logic [7:0] len, input logic [31:0] pl,
                            input logic [7:0] crc_xor, input logic [7:0] eof);
      byte_q_t     cq;
      logic [31:0] c, exp_data;
      ann_t        a;
      cq.push_back(id);
      cq.push_back(len);
      exp_data = 32'h0;
      for (int k = 0; k < int'(len); k++) begin
         cq.push_back(pl[31-8*k -: 8]);
         exp_data[31-8*k -: 8] = pl[31-8*k -: 8];
      end
      c = crc_ref(cq);
      c[7:0] = c[7:0] ^ crc_xor;
      add_hdr();
      foreach (cq[i]) add_body(cq[i], 1, EV_NONE);
      for (int k = 0; k < 4; k++) add_body(c[31-8*k -: 8], 1, EV_NONE);
      a.b = eof; a.busy = 0; a.id = id; a.len = len; a.data = exp_data;
      if (eof != 8'h55)         a.ev = EV_FRM;
      else if (crc_xor != 8'h0) a.ev = EV_CRC;
      else                      a.ev = EV_VALID;
      txq.push_back(a);
   endtask

   // ---------------- driver / expectation update ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         e_valid = 1'b0; e_crc = 1'b0; e_frm = 1'b0;
      end
   endtask

   task automatic send_q(input int gap);
      ann_t a;
      while (txq.size() > 0) begin
         a = txq.pop_front();
         bus.i_en = 1'b1; bus.i_data = a.b;
         @(posedge clk); #1;
         bus.i_en = 1'b0;
         e_valid = (a.ev == EV_VALID);
         e_crc   = (a.ev == EV_CRC);
         e_frm   = (a.ev == EV_FRM);
         if (a.busy != BUSY_KEEP) e_busy = a.busy[0];
         if (a.ev == EV_VALID) begin
            e_id = a.id; e_len = a.len; e_data = a.data;
         end
         repeat (gap) idle(1);
      end
      idle(2);
   endtask

   task automatic do_reset();
      rst = 1'b1; bus.i_en = 1'b0;
      @(posedge clk); #1;
      e_id = 8'h0; e_len = 8'h0; e_data = 32'h0;
      e_valid = 1'b0; e_crc = 1'b0; e_frm = 1'b0; e_busy = 1'b0;
      rst = 1'b0;
      chk_en = 1'b1;
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("o_id",        32'(bus.o_id),        32'(e_id));
         chk("o_len",       32'(bus.o_len),       32'(e_len));
         chk("o_data",      32'(bus.o_data),      e_data);
         chk("o_valid",     32'(bus.o_valid),     32'(e_valid));
         chk("o_crc_err",   32'(bus.o_crc_err),   32'(e_crc));
         chk("o_frame_err", 32'(bus.o_frame_err), 32'(e_frm));
         chk("o_busy",      32'(bus.o_busy),      32'(e_busy));
         if (bus.o_valid === 1'b1)     valid_seen++;
         if (bus.o_crc_err === 1'b1)   crc_seen++;
         if (bus.o_frame_err === 1'b1) frm_seen++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t chk_q;
      int      v0, f0, c0;
      bus.i_en = 1'b0; bus.i_data = 8'h00; body_aa = 0;

      // Pin the reference CRC with the standard check string "123456789".
      for (int k = 0; k < 9; k++) chk_q.push_back(8'h31 + 8'(k));
      chk("crc_ref_check", crc_ref(chk_q), 32'hCBF43926);

      repeat (2) @(posedge clk);
      #1;
      do_reset();
      idle(1);
      chk("rst_busy", 32'(bus.o_busy), 32'h0);
      chk("rst_data", 32'(bus.o_data), 32'h0);
      chk("rst_id",   32'(bus.o_id),   32'h0);

      // Good frame, back-to-back bytes.
      add_frame(8'h01, 8'd4, 32'h12345678, 8'h00, 8'h55);
      send_q(0);
      chk("b2b_id",   32'(bus.o_id),   32'h01);
      chk("b2b_len",  32'(bus.o_len),  32'h04);
      chk("b2b_data", 32'(bus.o_data), 32'h12345678);

      // Same frame, one byte every 166 cycles.
      add_frame(8'h01, 8'd4, 32'h12345678, 8'h00, 8'h55);
      send_q(165);
      chk("sparse_id",   32'(bus.o_id),   32'h01);
      chk("sparse_data", 32'(bus.o_data), 32'h12345678);

      // Payload AA AA 00 01 travels as AA AA 55 00 01.
      add_frame(8'h02, 8'd4, 32'hAAAA0001, 8'h00, 8'h55);
      send_q(0);
      chk("stuff_data", 32'(bus.o_data), 32'hAAAA0001);

      // Corrupted CRC: outputs keep the previous frame.
      add_frame(8'h01, 8'd4, 32'h12345678, 8'h01, 8'h55);
      send_q(0);
      chk("badcrc_data", 32'(bus.o_data), 32'hAAAA0001);
      chk("badcrc_id",   32'(bus.o_id),   32'h02);

      // Length above N_DATA_BYTE, then a short good frame.
      add_hdr();
      add_body(8'h01, 1, EV_NONE);
      add_body(8'h05, 0, EV_FRM);
      add_frame(8'h03, 8'd2, 32'hBEEF0000, 8'h00, 8'h55);
      send_q(0);
      chk("short_data", 32'(bus.o_data), 32'hBEEF0000);
      chk("short_len",  32'(bus.o_len),  32'h02);

      // Transport-frame ID, then a zero-length good frame.
      add_hdr();
      add_body(8'h81, 0, EV_FRM);
      add_frame(8'h04, 8'd0, 32'h0, 8'h00, 8'h55);
      send_q(0);
      chk("len0_data", 32'(bus.o_data), 32'h0);
      chk("len0_id",   32'(bus.o_id),   32'h04);

      // Wrong EOF byte.
      add_frame(8'h01, 8'd4, 32'h12345678, 8'h00, 8'h00);
      send_q(0);
      chk("noeof_id", 32'(bus.o_id), 32'h04);

      // Resync: abort after two payload bytes, the header starts the next frame.
      v0 = valid_seen; f0 = frm_seen; c0 = crc_seen;
      add_hdr();
      add_body(8'h05, 1, EV_NONE);
      add_body(8'h04, 1, EV_NONE);
      add_body(8'h11, 1, EV_NONE);
      add_body(8'h22, 1, EV_NONE);
      add_frame(8'h06, 8'd1, 32'h7E000000, 8'h00, 8'h55);
      send_q(0);
      chk("resync_valids", 32'(valid_seen - v0), 32'd1);
      chk("resync_errs",   32'((frm_seen - f0) + (crc_seen - c0)), 32'd0);
      chk("resync_data",   32'(bus.o_data), 32'h7E000000);

      // Reset in the middle of a payload.
      add_hdr();
      add_body(8'h01, 1, EV_NONE);
      add_body(8'h04, 1, EV_NONE);
      add_body(8'h12, 1, EV_NONE);
      add_body(8'h34, 1, EV_NONE);
      send_q(0);
      do_reset();
      chk("midrst_busy", 32'(bus.o_busy), 32'h0);
      chk("midrst_data", 32'(bus.o_data), 32'h0);
      idle(3);
      add_frame(8'h01, 8'd4, 32'h12345678, 8'h00, 8'h55);
      send_q(0);
      chk("post_rst_data", 32'(bus.o_data), 32'h12345678);

      chk("total_valid",  32'(valid_seen), 32'd7);
      chk("total_crcerr", 32'(crc_seen),   32'd1);
      chk("total_frmerr", 32'(frm_seen),   32'd3);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
